// File: rtl/zf_mid_feeder_if.sv
// Interface for the ZF mid-process feeder: operand input, midprocess handshake and result output.
// Modport master is the feeder and slave is its environment.
interface zf_mid_feeder_if #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
);
  localparam int FW = $clog2(DEPTH) + 1;

  logic          enable;
  logic          in_valid;
  logic          in_ready;
  logic [2*DW-1:0] in_q2;
  logic [2*DW-1:0] in_r;
  logic [2*DW-1:0] in_xpre;
  logic          mp_accept_in;
  logic          mp_ready_out;
  logic          mp_accept_out;
  logic [2*DW-1:0] mp_q2;
  logic [2*DW-1:0] mp_r;
  logic [2*DW-1:0] mp_xpre;
  logic [2*DW-1:0] mp_x_mid;
  logic          res_valid;
  logic          res_ready;
  logic [2*DW-1:0] res_x_mid;
  logic [2*DW-1:0] res_x_pre;
  logic [FW-1:0] fill;

  modport master (
    input  enable, in_valid, in_q2, in_r, in_xpre,
           mp_ready_out, mp_accept_out, mp_x_mid, res_ready,
    output in_ready, mp_accept_in, mp_q2, mp_r, mp_xpre,
           res_valid, res_x_mid, res_x_pre, fill
  );

  modport slave (
    output enable, in_valid, in_q2, in_r, in_xpre,
           mp_ready_out, mp_accept_out, mp_x_mid, res_ready,
    input  in_ready, mp_accept_in, mp_q2, mp_r, mp_xpre,
           res_valid, res_x_mid, res_x_pre, fill
  );
endinterface

// File: rtl/zf_mid_feeder.sv
// Operand FIFO and single-in-flight issue/collect FSM feeding midprocess_ZF.
// Optional WAIT timeout with sticky timeout_err port: define ZF_FEEDER_TIMEOUT_EN.
module zf_mid_feeder #(
  parameter int DW      = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  zf_mid_feeder_if.master bus
`ifdef ZF_FEEDER_TIMEOUT_EN
  ,
  output logic timeout_err
`endif
);
  // state | meaning
  // IDLE  | waiting for a buffered set and midprocess ready
  // ISSUE | mp_accept_in strobe, head operands presented
  // WAIT  | set in flight, waiting for mp_accept_out
  // HOLD  | result held on res_valid until res_ready
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]      state;
  logic [2*DW-1:0] q2_mem   [DEPTH];
  logic [2*DW-1:0] r_mem    [DEPTH];
  logic [2*DW-1:0] xpre_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [FW-1:0]   fill;
  logic [2*DW-1:0] res_x_mid;
  logic [2*DW-1:0] res_x_pre;
  logic            full;
  logic            push;
  logic            pop;
  logic            capture;
  logic            expire;

  assign full    = (fill == FW'(DEPTH));
  assign push    = bus.in_valid & bus.in_ready;
  assign capture = bus.enable & (state == WAIT) & bus.mp_accept_out;
  assign pop     = capture | expire;

  assign bus.in_ready     = reset_n & bus.enable & ~full;
  // Gated by enable so a frozen ISSUE cannot stretch into a multi-cycle strobe.
  assign bus.mp_accept_in = bus.enable & (state == ISSUE);
  assign bus.mp_q2        = q2_mem[rd_ptr];
  assign bus.mp_r         = r_mem[rd_ptr];
  assign bus.mp_xpre      = xpre_mem[rd_ptr];
  assign bus.res_valid    = (state == HOLD);
  assign bus.res_x_mid    = res_x_mid;
  assign bus.res_x_pre    = res_x_pre;
  assign bus.fill         = fill;

  always_ff @(posedge clk) begin
    if (push) begin
      q2_mem[wr_ptr]   <= bus.in_q2;
      r_mem[wr_ptr]    <= bus.in_r;
      xpre_mem[wr_ptr] <= bus.in_xpre;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fill <= fill + FW'(1);
      else if (!push && pop) fill <= fill - FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      res_x_mid <= '0;
      res_x_pre <= '0;
    end else if (bus.enable) begin
      case (state)
        IDLE:  if (fill != '0 && bus.mp_ready_out) state <= ISSUE;
        ISSUE: state <= WAIT;
        WAIT: begin
          if (capture) begin
            res_x_mid <= bus.mp_x_mid;
            res_x_pre <= xpre_mem[rd_ptr];
            state     <= HOLD;
          end else if (expire) begin
            state <= IDLE;
          end
        end
        HOLD:  if (bus.res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ZF_FEEDER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tcnt;

  assign expire = bus.enable & (state == WAIT) & ~bus.mp_accept_out & (tcnt == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else if (bus.enable) begin
      if (state == ISSUE)     tcnt <= '0;
      else if (state == WAIT) tcnt <= tcnt + CW'(1);
      if (expire) timeout_err <= 1'b1;
    end
  end
`else
  assign expire = 1'b0;
`endif
endmodule

// File: tb/tb_zf_mid_feeder.sv
// Self-checking bench for zf_mid_feeder; the bench plays midprocess_ZF and the result consumer.
module tb_zf_mid_feeder;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] q2;
    logic [31:0] r;
    logic [31:0] xpre;
  } set_t;

  logic clk;
  logic reset_n;
`ifdef ZF_FEEDER_TIMEOUT_EN
  logic timeout_err;
`endif

  zf_mid_feeder_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  zf_mid_feeder #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(15)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef ZF_FEEDER_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  set_t fq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic set_t rnd_set();
    set_t s;
    s.q2   = $urandom;
    s.r    = $urandom;
    s.xpre = $urandom;
    return s;
  endfunction

  task automatic push_try(input set_t s);
    logic exp_rdy;
    exp_rdy      = (fq.size() < DEPTH);
    bus.in_valid = 1'b1;
    bus.in_q2    = s.q2;
    bus.in_r     = s.r;
    bus.in_xpre  = s.xpre;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    step();
    if (exp_rdy) fq.push_back(s);
    bus.in_valid = 1'b0;
    chk("fill_after_push", 64'(bus.fill), 64'(fq.size()));
  endtask

  task automatic wait_issue();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.mp_accept_in) begin
        seen = 1'b1;
        break;
      end
    end
    chk("issue_seen", 64'(seen), 64'(1'b1));
    if (seen && fq.size() > 0) begin
      chk("mp_q2", 64'(bus.mp_q2), 64'(fq[0].q2));
      chk("mp_r", 64'(bus.mp_r), 64'(fq[0].r));
      chk("mp_xpre", 64'(bus.mp_xpre), 64'(fq[0].xpre));
    end
  endtask

  task automatic process_one();
    set_t        head;
    logic [31:0] xm;
    int          d;
    head = fq[0];
    wait_issue();
    step();
    chk("issue_one_cycle", 64'(bus.mp_accept_in), 64'(1'b0));
    d = $urandom_range(0, 3);
    for (int k = 0; k < d; k++) step();
    chk("no_result_before_accept", 64'(bus.res_valid), 64'(1'b0));
    xm = $urandom;
    bus.mp_accept_out = 1'b1;
    bus.mp_x_mid      = xm;
    step();
    bus.mp_accept_out = 1'b0;
    bus.mp_x_mid      = $urandom;
    void'(fq.pop_front());
    chk("res_valid", 64'(bus.res_valid), 64'(1'b1));
    chk("res_x_mid", 64'(bus.res_x_mid), 64'(xm));
    chk("res_x_pre", 64'(bus.res_x_pre), 64'(head.xpre));
    chk("fill_after_pop", 64'(bus.fill), 64'(fq.size()));
    d = $urandom_range(0, 2);
    for (int k = 0; k < d; k++) begin
      step();
      chk("res_hold_mid", 64'(bus.res_x_mid), 64'(xm));
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("res_released", 64'(bus.res_valid), 64'(1'b0));
  endtask

  initial begin
    set_t        s;
    logic [31:0] xa;
    logic [31:0] xb;
    logic        done;
    int          n;

    reset_n           = 1'b0;
    bus.enable        = 1'b1;
    bus.in_valid      = 1'b1;
    bus.in_q2         = 32'h1111_1111;
    bus.in_r          = 32'h2222_2222;
    bus.in_xpre       = 32'h3333_3333;
    bus.mp_ready_out  = 1'b0;
    bus.mp_accept_out = 1'b0;
    bus.mp_x_mid      = '0;
    bus.res_ready     = 1'b0;

    // Reset with in_valid held high
    step();
    step();
    chk("rst_fill", 64'(bus.fill), 64'd0);
    chk("rst_accept_in", 64'(bus.mp_accept_in), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_res_x_mid", 64'(bus.res_x_mid), 64'd0);
    bus.in_valid = 1'b0;
    reset_n      = 1'b1;
    step();
    chk("post_rst_fill", 64'(bus.fill), 64'd0);

    // Single directed set with known latencies
    bus.mp_ready_out = 1'b1;
    s.q2   = 32'h3333_1CCC;
    s.r    = 32'h0999_0666;
    s.xpre = 32'h0666_0E66;
    push_try(s);
    chk("t0_no_issue", 64'(bus.mp_accept_in), 64'd0);
    step();
    chk("t1_issue", 64'(bus.mp_accept_in), 64'd1);
    chk("t1_q2", 64'(bus.mp_q2), 64'h3333_1CCC);
    chk("t1_r", 64'(bus.mp_r), 64'h0999_0666);
    chk("t1_xpre", 64'(bus.mp_xpre), 64'h0666_0E66);
    step();
    chk("t2_issue_low", 64'(bus.mp_accept_in), 64'd0);
    step();
    step();
    bus.mp_accept_out = 1'b1;
    bus.mp_x_mid      = 32'h2A3D_1147;
    step();
    bus.mp_accept_out = 1'b0;
    void'(fq.pop_front());
    chk("single_res_valid", 64'(bus.res_valid), 64'd1);
    chk("single_x_mid", 64'(bus.res_x_mid), 64'h2A3D_1147);
    chk("single_x_pre", 64'(bus.res_x_pre), 64'h0666_0E66);
    chk("single_fill", 64'(bus.fill), 64'd0);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("single_released", 64'(bus.res_valid), 64'd0);
    step();
    chk("no_spurious_issue", 64'(bus.mp_accept_in), 64'd0);

    // Back-pressure: five offers into a four-deep FIFO, then drain in order
    bus.mp_ready_out = 1'b0;
    for (int i = 0; i < 5; i++) push_try(rnd_set());
    chk("bp_fill_full", 64'(bus.fill), 64'd4);
    chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    bus.mp_ready_out = 1'b1;
    while (fq.size() > 0) process_one();

    // Random rounds
    for (int rnd = 0; rnd < 4; rnd++) begin
      bus.mp_ready_out = 1'b0;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) push_try(rnd_set());
      bus.mp_ready_out = 1'b1;
      while (fq.size() > 0) process_one();
    end

    // Full FIFO: push offered on the capture edge is refused, next edge accepted
    bus.mp_ready_out = 1'b0;
    for (int i = 0; i < 4; i++) push_try(rnd_set());
    bus.mp_ready_out = 1'b1;
    wait_issue();
    step();
    xa = $urandom;
    s  = rnd_set();
    bus.mp_accept_out = 1'b1;
    bus.mp_x_mid      = xa;
    bus.in_valid      = 1'b1;
    bus.in_q2         = s.q2;
    bus.in_r          = s.r;
    bus.in_xpre       = s.xpre;
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    bus.mp_accept_out = 1'b0;
    chk("full_x_pre", 64'(bus.res_x_pre), 64'(fq[0].xpre));
    void'(fq.pop_front());
    chk("full_pop_fill", 64'(bus.fill), 64'd3);
    chk("full_in_ready_after", 64'(bus.in_ready), 64'd1);
    step();
    fq.push_back(s);
    bus.in_valid = 1'b0;
    chk("full_push_fill", 64'(bus.fill), 64'd4);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    while (fq.size() > 0) process_one();

    // Enable gating while WAIT
    push_try(rnd_set());
    wait_issue();
    step();
    xa = $urandom;
    xb = $urandom;
    bus.enable        = 1'b0;
    bus.mp_accept_out = 1'b1;
    bus.mp_x_mid      = xa;
    step();
    bus.mp_accept_out = 1'b0;
    chk("gate_no_capture", 64'(bus.res_valid), 64'd0);
    chk("gate_fill", 64'(bus.fill), 64'd1);
    chk("gate_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    bus.enable = 1'b1;
    step();
    chk("gate_still_wait", 64'(bus.res_valid), 64'd0);
    chk("gate_no_reissue", 64'(bus.mp_accept_in), 64'd0);
    bus.mp_accept_out = 1'b1;
    bus.mp_x_mid      = xb;
    step();
    bus.mp_accept_out = 1'b0;
    void'(fq.pop_front());
    chk("gate_capture", 64'(bus.res_valid), 64'd1);
    chk("gate_x_mid", 64'(bus.res_x_mid), 64'(xb));
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;

`ifdef ZF_FEEDER_TIMEOUT_EN
    // Midprocess never answers
    push_try(rnd_set());
    wait_issue();
    chk("to_err_before", 64'(timeout_err), 64'd0);
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.fill == '0) begin
        done = 1'b1;
        break;
      end
    end
    void'(fq.pop_front());
    chk("to_expired", 64'(done), 64'd1);
    chk("to_err", 64'(timeout_err), 64'd1);
    chk("to_fill", 64'(bus.fill), 64'(fq.size()));
    chk("to_no_result", 64'(bus.res_valid), 64'd0);
    step();
    chk("to_err_sticky", 64'(timeout_err), 64'd1);
`else
    done = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
